// File: rtl/burst_pattern_gen.sv
// Multi-channel counting burst generator: burst, hold window, optional loop, valid/ready output.
// Define BURST_PATTERN_GEN_XOUT_EN to drive o_data to all-x whenever o_valid is low.
module burst_pattern_gen #(
    parameter int DW    = 4,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DW-1:0]       cfg_init,
    input  logic [DW-1:0]       cfg_step,
    input  logic [CNT_W-1:0]    cfg_burst_len,
    input  logic [CNT_W-1:0]    cfg_hold_len,
    input  logic                cfg_loop,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [NCH*DW-1:0]   o_data,
    output logic                busy,
    output logic                ev_burst,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    logic [DW-1:0]      value;
    logic [DW-1:0]      init_q;
    logic [DW-1:0]      step_q;
    logic [CNT_W-1:0]   blen_q;
    logic [CNT_W-1:0]   hlen_q;
    logic               loop_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   hold_cnt;
    logic [NCH*DW-1:0]  data_q;
    logic               valid_q;
    logic               busy_q;
    logic               ev_q;
    logic               done_q;

    logic               hs;
    logic               last_beat;
    logic               hold_end;
    logic [DW-1:0]      next_value;

    function automatic logic [NCH*DW-1:0] fan_out(input logic [DW-1:0] base);
        logic [NCH*DW-1:0] d;
        d = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            d[c*DW +: DW] = base + DW'(c);
        end
        return d;
    endfunction

    assign hs         = valid_q & o_ready;
    // Lengths are nonzero whenever these are consulted, so len-1 never underflows.
    assign last_beat  = (beat_cnt == blen_q - CNT_W'(1));
    assign hold_end   = (hold_cnt == hlen_q - CNT_W'(1));
    assign next_value = value + step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            value    <= '0;
            init_q   <= '0;
            step_q   <= '0;
            blen_q   <= '0;
            hlen_q   <= '0;
            loop_q   <= 1'b0;
            beat_cnt <= '0;
            hold_cnt <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ev_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ev_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        init_q   <= cfg_init;
                        step_q   <= cfg_step;
                        blen_q   <= cfg_burst_len;
                        hlen_q   <= cfg_hold_len;
                        loop_q   <= cfg_loop;
                        value    <= cfg_init;
                        beat_cnt <= '0;
                        hold_cnt <= '0;
                        busy_q   <= 1'b1;
                        if (cfg_burst_len == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            valid_q <= 1'b1;
                            ev_q    <= 1'b1;
                            data_q  <= fan_out(cfg_init);
                        end
                    end
                end

                S_RUN: begin
                    if (hs) begin
                        value    <= next_value;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    // Abort wins over the exit decision; the beat above is still counted.
                    if (abort) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (hs) begin
                        if (!last_beat) begin
                            data_q <= fan_out(next_value);
                        end else if (hlen_q != '0) begin
                            state    <= S_HOLD;
                            valid_q  <= 1'b0;
                            hold_cnt <= '0;
                        end else if (loop_q) begin
                            ev_q     <= 1'b1;
                            value    <= init_q;
                            beat_cnt <= '0;
                            data_q   <= fan_out(init_q);
                        end else begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (hold_end) begin
                        if (loop_q) begin
                            state    <= S_RUN;
                            valid_q  <= 1'b1;
                            ev_q     <= 1'b1;
                            value    <= init_q;
                            beat_cnt <= '0;
                            data_q   <= fan_out(init_q);
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid  = valid_q;
    assign busy     = busy_q;
    assign ev_burst = ev_q;
    assign done     = done_q;

`ifdef BURST_PATTERN_GEN_XOUT_EN
    assign o_data = valid_q ? data_q : {(NCH*DW){1'bx}};
`else
    assign o_data = data_q;
`endif

endmodule

// File: tb/tb_burst_pattern_gen.sv
// Self-checking bench for burst_pattern_gen: vector table plus corner-case sequences,
// with a beat scoreboard checked against o_data whenever o_valid is high.
module tb_burst_pattern_gen;

    localparam int DW    = 4;
    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int LIMIT = 2000;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [DW-1:0]      cfg_init;
    logic [DW-1:0]      cfg_step;
    logic [CNT_W-1:0]   cfg_burst_len;
    logic [CNT_W-1:0]   cfg_hold_len;
    logic               cfg_loop;
    logic               o_valid;
    logic               o_ready;
    logic [NCH*DW-1:0]  o_data;
    logic               busy;
    logic               ev_burst;
    logic               done;

    burst_pattern_gen #(.DW(DW), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_init(cfg_init), .cfg_step(cfg_step),
        .cfg_burst_len(cfg_burst_len), .cfg_hold_len(cfg_hold_len),
        .cfg_loop(cfg_loop), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .busy(busy), .ev_burst(ev_burst), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int init;
        int step;
        int blen;
        int hlen;
        int exp_hs;
        int exp_last;
        int exp_cycles;
        int exp_hold;
        int exp_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [NCH*DW-1:0] sb[$];
    int hs_cnt, ev_cnt, busy_cnt, hold_obs, done_cnt;
    logic [DW-1:0] last_ch0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*DW-1:0] chan(input logic [DW-1:0] base);
        logic [NCH*DW-1:0] d;
        d = '0;
        for (int c = 0; c < NCH; c++) d[c*DW +: DW] = base + DW'(c);
        return d;
    endfunction

    task automatic push_burst(input int init, input int stp, input int blen);
        logic [DW-1:0] v;
        v = DW'(init);
        for (int i = 0; i < blen; i++) begin
            sb.push_back(chan(v));
            v = v + DW'(stp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input vec_t v, input logic lp);
        cfg_init      = DW'(v.init);
        cfg_step      = DW'(v.step);
        cfg_burst_len = CNT_W'(v.blen);
        cfg_hold_len  = CNT_W'(v.hlen);
        cfg_loop      = lp;
        hs_cnt = 0; ev_cnt = 0; busy_cnt = 0; hold_obs = 0; done_cnt = 0; last_ch0 = '0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int n;
        push_burst(v.init, v.step, v.blen);
        launch(v, 1'b0);
        wait_done(n);
        chk("done_latency", n, v.exp_cycles);
        step();
        chk("busy_after_done", busy, 0);
        chk("handshakes", hs_cnt, v.exp_hs);
        chk("ev_burst_count", ev_cnt, (v.blen > 0) ? 1 : 0);
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("hold_cycles", hold_obs, v.exp_hold);
        chk("done_pulses", done_cnt, 1);
        chk("sb_drained", sb.size(), 0);
        if (v.blen > 0) chk("last_ch0", last_ch0, v.exp_last);
    endtask

    // Data must match the scoreboard head on every valid cycle, stalled or not.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("beat_data", o_data, sb[0]);
                    if (o_ready) void'(sb.pop_front());
                end
                if (o_ready) begin
                    hs_cnt++;
                    last_ch0 = o_data[DW-1:0];
                end
            end
            if (ev_burst) ev_cnt++;
            if (busy) busy_cnt++;
            if (busy && !o_valid && !done) hold_obs++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    vec_t vecs[7];
    vec_t rv;
    vec_t tv;
    int   n;

    initial begin
        //          init step blen hlen hs last cyc hold busy
        vecs[0] = '{0,   1,   10,  10,  10, 9,   20, 10,  21};
        vecs[1] = '{14,  1,   4,   0,   4,  1,   4,  0,   5};
        vecs[2] = '{0,   1,   0,   5,   0,  0,   0,  0,   1};
        vecs[3] = '{3,   5,   6,   1,   6,  12,  7,  1,   8};
        vecs[4] = '{15,  15,  3,   0,   3,  13,  3,  0,   4};
        vecs[5] = '{7,   0,   1,   2,   1,  7,   3,  2,   4};
        vecs[6] = '{0,   1,   255, 0,   255, 14, 255, 0,  256};

        rst = 1'b1; start = 1'b0; abort = 1'b0; o_ready = 1'b1;
        cfg_init = '0; cfg_step = '0; cfg_burst_len = '0; cfg_hold_len = '0; cfg_loop = 1'b0;
        step(); step(); step();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ev", ev_burst, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vector(vecs[i]);

        // start together with abort in IDLE is dropped
        tv = '{1, 1, 3, 0, 0, 0, 0, 0, 0};
        abort = 1'b1;
        launch(tv, 1'b0);
        abort = 1'b0;
        chk("startabort_busy", busy, 0);
        chk("startabort_valid", o_valid, 0);
        step();
        chk("startabort_busy2", busy, 0);

        // backpressure with value wrap, ready toggling 1,0,1,0...
        tv = '{14, 1, 4, 0, 0, 0, 0, 0, 0};
        push_burst(14, 1, 4);
        o_ready = 1'b1;
        launch(tv, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            step();
            n++;
            o_ready = ~o_ready;
        end
        chk("bp_latency", n, 7);
        chk("bp_handshakes", hs_cnt, 4);
        chk("bp_last_ch0", last_ch0, 1);
        o_ready = 1'b1;
        step();
        chk("bp_sb_drained", sb.size(), 0);

        // loop with abort in the second cycle of the second hold window
        tv = '{2, 3, 3, 2, 0, 0, 0, 0, 0};
        push_burst(2, 3, 3);
        push_burst(2, 3, 3);
        launch(tv, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk("loop_ev", ev_burst, ((k % 5) == 0));
            chk("loop_valid", o_valid, ((k % 5) < 3));
            chk("loop_busy", busy, 1);
            if (k == 9) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        chk("abort_valid", o_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        step(); step(); step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_hs", hs_cnt, 6);
        chk("abort_ev", ev_cnt, 2);
        chk("abort_idle_busy", busy, 0);
        chk("abort_sb_drained", sb.size(), 0);

        // reset during beat 5 of 10, then a clean burst from init
        rv = '{5, 2, 10, 3, 10, 7, 13, 3, 14};
        push_burst(5, 2, 10);
        launch(rv, 1'b0);
        for (int k = 0; k < 4; k++) step();
        chk("mid_hs", hs_cnt, 4);
        rst = 1'b1;
        step();
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ev", ev_burst, 0);
        chk("midrst_done", done, 0);
        sb.delete();
        rst = 1'b0;
        step();
        run_vector(rv);

        // start during RUN with different config is ignored
        tv = '{1, 2, 5, 1, 0, 0, 0, 0, 0};
        push_burst(1, 2, 5);
        launch(tv, 1'b0);
        step(); step();
        cfg_init = 4'd9; cfg_step = 4'd7; cfg_burst_len = 8'd2; cfg_hold_len = 8'd0; cfg_loop = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        chk("ign_latency", n + 3, 6);
        step();
        chk("ign_busy_after", busy, 0);
        chk("ign_hs", hs_cnt, 5);
        chk("ign_last_ch0", last_ch0, 9);
        chk("ign_ev", ev_cnt, 1);
        chk("ign_done", done_cnt, 1);
        chk("ign_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
